// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/point pacing in frame ticks, score keeping,
// ball gating and a debounced-by-lockout start/pause button.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned LOCK_FRAMES  = 8
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        miss_left,
  input  logic        miss_right,
  output logic        ball_en,
  output logic        ball_reset,
  output logic        serve_dir,
  output logic [15:0] score,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state_out
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCORE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_PAUSE    = 3'd3,
    S_POINT    = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  state_t state, state_next;

  logic               sync1, sync2, sync3;
  logic [CNT_W-1:0]   lock_cnt;
  logic [CNT_W-1:0]   frame_cnt;
  logic               first;
  logic [SCORE_W-1:0] score_l, score_r;

  logic               press_c;
  logic               frame_inc_c;
  logic               miss_l_only_c;
  logic               miss_r_only_c;
  logic [SCORE_W-1:0] score_l_inc_c, score_r_inc_c;

  logic [SCORE_W-1:0] score_l_d, score_r_d;
  logic               serve_dir_d, winner_d;
  logic               ball_en_d, ball_reset_d, game_over_d;

  // Button synchroniser; sync2/sync3 form the rising-edge detector
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= start_btn;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign press_c       = sync2 & ~sync3 & (lock_cnt == '0);
  assign frame_inc_c   = frame_tick & ~first;
  assign miss_l_only_c = miss_left & ~miss_right;
  assign miss_r_only_c = miss_right & ~miss_left;
  assign score_l_inc_c = score_l + SCORE_W'(1);
  assign score_r_inc_c = score_r + SCORE_W'(1);

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (press_c) state_next = S_SERVE;
      S_SERVE: if (frame_inc_c && frame_cnt == CNT_W'(SERVE_FRAMES - 1)) state_next = S_PLAY;
      S_PLAY: begin
        if (miss_l_only_c)
          state_next = (score_r_inc_c == SCORE_W'(WIN_SCORE)) ? S_GAMEOVER : S_POINT;
        else if (miss_r_only_c)
          state_next = (score_l_inc_c == SCORE_W'(WIN_SCORE)) ? S_GAMEOVER : S_POINT;
        else if (miss_left && miss_right)
          state_next = S_POINT;
        else if (press_c)
          state_next = S_PAUSE;
      end
      S_PAUSE:    if (press_c) state_next = S_PLAY;
      S_POINT:    if (frame_inc_c && frame_cnt == CNT_W'(POINT_FRAMES - 1)) state_next = S_SERVE;
      S_GAMEOVER: if (press_c) state_next = S_SERVE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    score_l_d    = score_l;
    score_r_d    = score_r;
    serve_dir_d  = serve_dir;
    winner_d     = winner;
    ball_en_d    = (state_next == S_PLAY);
    ball_reset_d = (state_next == S_SERVE) && (state != S_SERVE);
    game_over_d  = (state_next == S_GAMEOVER);
    case (state)
      S_PLAY: begin
        if (miss_l_only_c) begin
          score_r_d   = score_r_inc_c;
          serve_dir_d = 1'b0;
          if (score_r_inc_c == SCORE_W'(WIN_SCORE)) winner_d = 1'b1;
        end else if (miss_r_only_c) begin
          score_l_d   = score_l_inc_c;
          serve_dir_d = 1'b1;
          if (score_l_inc_c == SCORE_W'(WIN_SCORE)) winner_d = 1'b0;
        end
      end
      S_GAMEOVER: begin
        if (press_c) begin
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      score_l    <= '0;
      score_r    <= '0;
      serve_dir  <= 1'b0;
      winner     <= 1'b0;
      ball_en    <= 1'b0;
      ball_reset <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      score_l    <= score_l_d;
      score_r    <= score_r_d;
      serve_dir  <= serve_dir_d;
      winner     <= winner_d;
      ball_en    <= ball_en_d;
      ball_reset <= ball_reset_d;
      game_over  <= game_over_d;
    end
  end

  // Frame counter restarts on every state change; the entry cycle's tick is skipped
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      frame_cnt <= '0;
      first     <= 1'b0;
    end else begin
      first <= (state_next != state);
      if (state_next != state)
        frame_cnt <= '0;
      else if (frame_inc_c && (state == S_SERVE || state == S_POINT))
        frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Press lockout keeps running in every state, including PAUSE
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset)
      lock_cnt <= '0;
    else if (press_c)
      lock_cnt <= CNT_W'(LOCK_FRAMES);
    else if (frame_tick && lock_cnt != '0)
      lock_cnt <= lock_cnt - CNT_W'(1);
  end

  assign score     = {4'h0, score_l, 4'h0, score_r};
  assign state_out = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: vector table, directed pause/reset sequences,
// then random play against a rule-level reference model.
module tb_pong_match_ctrl;

  localparam int WIN = 3;
  localparam int SRV = 2;
  localparam int PNT = 2;
  localparam int LCK = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ft, btn, ml, mr;
  logic        ball_en, ball_reset, serve_dir, game_over, winner;
  logic [15:0] score;
  logic [2:0]  state_out;

  int n_cmp = 0;
  int n_bad = 0;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SRV), .POINT_FRAMES(PNT), .LOCK_FRAMES(LCK)
  ) dut (
    .ClkPort(clk), .Reset(rst), .frame_tick(ft), .start_btn(btn),
    .miss_left(ml), .miss_right(mr), .ball_en(ball_en), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .score(score), .game_over(game_over), .winner(winner),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Reference model: game state as plain numbers, button history as a queue
  int m_st, m_frames, m_lock, m_sl, m_sr;
  bit m_sd, m_win, m_first, m_be, m_br, m_go;
  bit bq[$];

  function automatic void model_reset();
    m_st = 0; m_frames = 0; m_lock = 0; m_sl = 0; m_sr = 0;
    m_sd = 0; m_win = 0; m_first = 0; m_be = 0; m_br = 0; m_go = 0;
    bq = '{0, 0, 0};
  endfunction

  function automatic void model_step(input bit b, input bit f, input bit l, input bit r);
    bit acc;
    int nst;
    acc = bq[1] && !bq[2] && (m_lock == 0);
    nst = m_st;
    case (m_st)
      0: if (acc) nst = 1;
      1: if (f && !m_first) begin m_frames++; if (m_frames == SRV) nst = 2; end
      2: begin
        if (l && !r) begin
          m_sr++; m_sd = 0;
          if (m_sr == WIN) begin nst = 5; m_win = 1; end else nst = 4;
        end else if (r && !l) begin
          m_sl++; m_sd = 1;
          if (m_sl == WIN) begin nst = 5; m_win = 0; end else nst = 4;
        end else if (l && r) nst = 4;
        else if (acc) nst = 3;
      end
      3: if (acc) nst = 2;
      4: if (f && !m_first) begin m_frames++; if (m_frames == PNT) nst = 1; end
      5: if (acc) begin m_sl = 0; m_sr = 0; m_win = 0; nst = 1; end
      default: nst = 0;
    endcase
    if (acc) m_lock = LCK;
    else if (f && m_lock > 0) m_lock--;
    m_br = (nst == 1) && (m_st != 1);
    m_be = (nst == 2);
    m_go = (nst == 5);
    if (nst != m_st) begin m_frames = 0; m_first = 1; end
    else m_first = 0;
    m_st = nst;
    bq.push_front(b);
    void'(bq.pop_back());
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " state"}, int'(state_out), m_st);
    chk({tag, " score"}, int'(score), m_sl * 256 + m_sr);
    chk({tag, " ball_en"}, int'(ball_en), int'(m_be));
    chk({tag, " ball_reset"}, int'(ball_reset), int'(m_br));
    chk({tag, " serve_dir"}, int'(serve_dir), int'(m_sd));
    chk({tag, " game_over"}, int'(game_over), int'(m_go));
    chk({tag, " winner"}, int'(winner), int'(m_win));
  endtask

  // One clock: drive, step the model on the edge, check just after it
  task automatic cyc(input bit b, input bit f, input bit l, input bit r, input string tag);
    btn = b; ft = f; ml = l; mr = r;
    @(posedge clk);
    model_step(b, f, l, r);
    #1;
    chk_model(tag);
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (m_st != target && n < budget) begin
      cyc(0, 1, 0, 0, tag);
      n++;
    end
    chk({tag, " reached"}, int'(state_out), target);
  endtask

  typedef struct {
    bit b, f, l, r;
    int st;
    int sc;
    bit be, br, sd, go, wn;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit b, input bit f, input bit l, input bit r, input int st,
                              input int sc, input bit be, input bit br, input bit sd,
                              input bit go, input bit wn);
    vec_t v;
    v.b = b; v.f = f; v.l = l; v.r = r; v.st = st; v.sc = sc;
    v.be = be; v.br = br; v.sd = sd; v.go = go; v.wn = wn;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; ft = 0; btn = 0; ml = 0; mr = 0;
    model_reset();

    //   b f l r  st sc       be br sd go wn
    add(1,0,0,0, 0,'h0000, 0,0,0,0,0);
    add(1,0,0,0, 0,'h0000, 0,0,0,0,0);
    add(1,0,0,0, 1,'h0000, 0,1,0,0,0);
    add(1,0,0,0, 1,'h0000, 0,0,0,0,0);
    add(0,1,0,0, 1,'h0000, 0,0,0,0,0);
    add(0,1,0,0, 2,'h0000, 1,0,0,0,0);
    add(0,0,1,0, 4,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 4,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 4,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 1,'h0001, 0,1,0,0,0);
    add(0,1,0,0, 1,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 1,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 2,'h0001, 1,0,0,0,0);
    add(0,0,1,1, 4,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 4,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 4,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 1,'h0001, 0,1,0,0,0);
    add(0,1,0,0, 1,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 1,'h0001, 0,0,0,0,0);
    add(0,1,0,0, 2,'h0001, 1,0,0,0,0);
    add(0,0,0,1, 4,'h0101, 0,0,1,0,0);
    add(0,1,0,0, 4,'h0101, 0,0,1,0,0);
    add(0,1,0,0, 4,'h0101, 0,0,1,0,0);
    add(0,1,0,0, 1,'h0101, 0,1,1,0,0);
    add(0,1,0,0, 1,'h0101, 0,0,1,0,0);
    add(0,1,0,0, 1,'h0101, 0,0,1,0,0);
    add(0,1,0,0, 2,'h0101, 1,0,1,0,0);
    add(0,0,1,0, 4,'h0102, 0,0,0,0,0);
    add(0,1,0,0, 4,'h0102, 0,0,0,0,0);
    add(0,1,0,0, 4,'h0102, 0,0,0,0,0);
    add(0,1,0,0, 1,'h0102, 0,1,0,0,0);
    add(0,1,0,0, 1,'h0102, 0,0,0,0,0);
    add(0,1,0,0, 1,'h0102, 0,0,0,0,0);
    add(0,1,0,0, 2,'h0102, 1,0,0,0,0);
    add(0,0,1,0, 5,'h0103, 0,0,0,1,1);
    add(0,1,1,0, 5,'h0103, 0,0,0,1,1);
    add(1,0,0,0, 5,'h0103, 0,0,0,1,1);
    add(1,0,0,0, 5,'h0103, 0,0,0,1,1);
    add(1,0,0,0, 1,'h0000, 0,1,0,0,0);
    add(0,0,0,0, 1,'h0000, 0,0,0,0,0);

    #12;
    chk("reset state", int'(state_out), 0);
    chk("reset score", int'(score), 0);
    chk("reset outs", int'({ball_en, ball_reset, serve_dir, game_over, winner}), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("tbl[%0d]", i);
      cyc(tbl[i].b, tbl[i].f, tbl[i].l, tbl[i].r, t);
      chk({t, " st"}, int'(state_out), tbl[i].st);
      chk({t, " sc"}, int'(score), tbl[i].sc);
      chk({t, " be"}, int'(ball_en), int'(tbl[i].be));
      chk({t, " br"}, int'(ball_reset), int'(tbl[i].br));
      chk({t, " sd"}, int'(serve_dir), int'(tbl[i].sd));
      chk({t, " go"}, int'(game_over), int'(tbl[i].go));
      chk({t, " wn"}, int'(winner), int'(tbl[i].wn));
    end

    // Pause, ignored miss, bounce under lockout, resume
    run_until(2, 10, "to_play");
    cyc(1, 0, 0, 0, "pz"); cyc(1, 0, 0, 0, "pz"); cyc(1, 0, 0, 0, "pz");
    chk("pause state", int'(state_out), 3);
    chk("pause ball_en", int'(ball_en), 0);
    cyc(1, 0, 0, 1, "pz_miss");
    chk("pause miss score", int'(score), 0);
    cyc(0, 0, 0, 0, "bounce"); cyc(1, 0, 0, 0, "bounce");
    cyc(1, 0, 0, 0, "bounce"); cyc(1, 0, 0, 0, "bounce");
    chk("bounce ignored", int'(state_out), 3);
    cyc(1, 1, 0, 0, "pz_tick");
    cyc(0, 0, 0, 0, "resume"); cyc(1, 0, 0, 0, "resume");
    cyc(1, 0, 0, 0, "resume"); cyc(1, 0, 0, 0, "resume");
    chk("resume state", int'(state_out), 2);
    chk("resume ball_en", int'(ball_en), 1);

    // Build score 0x0201 then reset asynchronously mid-cycle
    cyc(0, 0, 0, 1, "s6"); run_until(2, 20, "s6");
    cyc(0, 0, 0, 1, "s6"); run_until(2, 20, "s6");
    cyc(0, 0, 1, 0, "s6"); run_until(2, 20, "s6");
    chk("pre-reset score", int'(score), 'h0201);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("async rst score", int'(score), 0);
    chk("async rst state", int'(state_out), 0);
    chk("async rst ball_en", int'(ball_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)), "post_rst");
      chk("post_rst idle", int'(state_out), 0);
    end
    cyc(1, 0, 0, 0, "post_rst_press"); cyc(1, 0, 0, 0, "post_rst_press");
    cyc(1, 0, 0, 0, "post_rst_press");
    chk("post_rst serve", int'(state_out), 1);

    // Random play
    for (int i = 0; i < 6000; i++) begin
      bit b;
      b = btn;
      if ($urandom_range(0, 7) == 0) b = ~b;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk_model("rnd_rst");
        @(posedge clk);
        #1 rst = 1'b0;
      end
      cyc(b, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
